// File: rtl/div_seq_if.sv
// div_seq_if: start/done handshake and operand/result bundle for div_seq.
//
// Parameters:
//   DVD_W - dividend and quotient width
//   DVS_W - divisor and remainder width
// Signals:
//   Start     - request, sampled only while the divider is accepting
//   Dividend  - dividend operand, captured on the accepting edge
//   Divisor   - divisor operand, captured on the accepting edge
//   Sgn       - signed-mode select (only when DIV_SIGNED_EN is defined)
//   Busy      - divider is working on an operation
//   Done      - one-cycle pulse, results valid
//   Quotient  - registered quotient, held until the next Done
//   Remainder - registered remainder, held until the next Done
//   DivZero   - registered divide-by-zero flag, held with Quotient
// Modports:
//   master - requester side (drives operands and Start)
//   slave  - divider side (drives status and results)
// Configuration macro: DIV_SIGNED_EN adds the Sgn signal.
interface div_seq_if #(
    parameter int DVD_W = 25,
    parameter int DVS_W = 17
);
    logic             Start;
    logic [DVD_W-1:0] Dividend;
    logic [DVS_W-1:0] Divisor;
`ifdef DIV_SIGNED_EN
    logic             Sgn;
`endif
    logic             Busy;
    logic             Done;
    logic [DVD_W-1:0] Quotient;
    logic [DVS_W-1:0] Remainder;
    logic             DivZero;

    modport master (
        output Start, Dividend, Divisor,
`ifdef DIV_SIGNED_EN
        output Sgn,
`endif
        input  Busy, Done, Quotient, Remainder, DivZero
    );

    modport slave (
        input  Start, Dividend, Divisor,
`ifdef DIV_SIGNED_EN
        input  Sgn,
`endif
        output Busy, Done, Quotient, Remainder, DivZero
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential non-restoring divider, one quotient bit per clock
// through a single shared add/subtract stage.
//
// Parameters:
//   DVD_W - dividend/quotient width (>= 2)
//   DVS_W - divisor/remainder width (2 <= DVS_W <= DVD_W)
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - div_seq_if.slave: Start/Dividend/Divisor(/Sgn) in,
//           Busy/Done/Quotient/Remainder/DivZero out
// Configuration macro:
//   DIV_SIGNED_EN - adds two's-complement mode selected by Sgn. Quotient
//                   truncates toward zero, remainder takes the dividend sign.
//
// Latency: Start accepted on edge k gives Done in the cycle after edge
// k+DVD_W+2 (k+2 for a zero divisor). Start is honoured in DONE, so
// back-to-back operations run every DVD_W+3 cycles.
module div_seq #(
    parameter int DVD_W = 25,
    parameter int DVS_W = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    div_seq_if.slave    bus
);

    localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Captured operands (held from the accepting edge until the next accept)
    logic [DVD_W-1:0]        dvd_r;
    logic [DVS_W-1:0]        dvs_r;
`ifdef DIV_SIGNED_EN
    logic                    sgn_r;
`endif

    // Working datapath
    logic [DVS_W-1:0]        dvs_mag;
    logic [DVD_W-1:0]        dq;        // dividend bits shift out of the top, quotient bits in at the bottom
    logic signed [DVS_W:0]   p;         // partial remainder, two's complement
    logic signed [DVS_W:0]   p_sh;
    logic signed [DVS_W:0]   p_step;
    logic signed [DVS_W:0]   dvs_ext;
    logic [DVS_W-1:0]        rem_mag;
    logic [CNT_W-1:0]        cnt;
    logic                    dz_r;
    logic                    accept;

    // Result registers
    logic [DVD_W-1:0]        quo_r;
    logic [DVS_W-1:0]        rem_r;
    logic                    divzero_r;

`ifdef DIV_SIGNED_EN
    logic                    neg_q;
    logic                    neg_r;

    function automatic logic [DVD_W-1:0] f_mag_dvd(input logic [DVD_W-1:0] v, input logic s);
        // The most negative value maps onto its own unsigned magnitude.
        return (s && v[DVD_W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DVS_W-1:0] f_mag_dvs(input logic [DVS_W-1:0] v, input logic s);
        return (s && v[DVS_W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DVD_W-1:0] f_neg_quo(input logic [DVD_W-1:0] v, input logic n);
        // -MIN / -1 yields magnitude 2^(DVD_W-1), which already reads as MIN.
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DVS_W-1:0] f_neg_rem(input logic [DVS_W-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign neg_q = sgn_r & (dvd_r[DVD_W-1] ^ dvs_r[DVS_W-1]);
    assign neg_r = sgn_r & dvd_r[DVD_W-1];
`endif

    assign accept  = ((state == S_IDLE) || (state == S_DONE)) && bus.Start;
    assign dvs_ext = {1'b0, dvs_mag};

    // One non-restoring step. The shift drops P's MSB; the arithmetic stays
    // correct modulo 2^(DVS_W+1) and the result always lies in [-D, D).
    always_comb begin
        p_sh   = {p[DVS_W-1:0], dq[DVD_W-1]};
        p_step = p[DVS_W] ? (p_sh + dvs_ext) : (p_sh - dvs_ext);
    end

    // Final correction: a negative P is restored by one add. Only the low
    // DVS_W bits are needed since the corrected value is in [0, D).
    assign rem_mag = p[DVS_W] ? (p[DVS_W-1:0] + dvs_mag) : p[DVS_W-1:0];

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = accept ? S_LOAD : S_IDLE;
            // A zero divisor skips ITER but still passes FIX, which is where
            // results are written; that gives the two-cycle zero-divide path.
            S_LOAD:  state_nxt = (dvs_r == '0) ? S_FIX : S_ITER;
            S_ITER:  state_nxt = (cnt == CNT_W'(DVD_W - 1)) ? S_FIX : S_ITER;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        bus.Busy = 1'b0;
        bus.Done = 1'b0;
        case (state)
            S_LOAD, S_ITER, S_FIX: bus.Busy = 1'b1;
            S_DONE:                bus.Done = 1'b1;
            default: ;
        endcase
    end

    // ---- Control: bit counter and zero-divisor flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dz_r <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    cnt  <= '0;
                    dz_r <= (dvs_r == '0);
                end
                S_ITER:  cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // ---- Datapath: operand capture, load and iterate ----
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_r <= bus.Dividend;
            dvs_r <= bus.Divisor;
`ifdef DIV_SIGNED_EN
            sgn_r <= bus.Sgn;
`endif
        end
        case (state)
            S_LOAD: begin
                p <= '0;
`ifdef DIV_SIGNED_EN
                dq      <= f_mag_dvd(dvd_r, sgn_r);
                dvs_mag <= f_mag_dvs(dvs_r, sgn_r);
`else
                dq      <= dvd_r;
                dvs_mag <= dvs_r;
`endif
            end
            S_ITER: begin
                p  <= p_step;
                dq <= {dq[DVD_W-2:0], ~p_step[DVS_W]};
            end
            default: ;
        endcase
    end

    // ---- Results: written in FIX, i.e. on the edge that raises Done ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_r     <= '0;
            rem_r     <= '0;
            divzero_r <= 1'b0;
        end else if (state == S_FIX) begin
            if (dz_r) begin
                quo_r     <= '1;
                rem_r     <= '0;
                divzero_r <= 1'b1;
            end else begin
`ifdef DIV_SIGNED_EN
                quo_r <= f_neg_quo(dq, neg_q);
                rem_r <= f_neg_rem(rem_mag, neg_r);
`else
                quo_r <= dq;
                rem_r <= rem_mag;
`endif
                divzero_r <= 1'b0;
            end
        end
    end

    assign bus.Quotient  = quo_r;
    assign bus.Remainder = rem_r;
    assign bus.DivZero   = divzero_r;

endmodule
